circle_raster_v2: RTL and testbench

Parametrised midpoint-circle rasteriser. Streams pixel addresses for an outline or filled circle into the framebuffer write path over a valid/ready handshake. Adds four things to the first-generation circle engine: configurable screen geometry, fill mode, screen clipping and backpressure. Sits between the primitive decoder (start/params) and the pixel writer (pix_* stream).

---
 rtl/raster_pkg.sv | 33 +++
 rtl/raster_clip.sv | 38 +++
 rtl/circle_raster_v2.sv | 197 +++++++++++++++++++
 tb/tb_circle_raster_v2.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : raster_pkg
//  Description : Shared types and screen defaults for the raster engines
//                (circle and line rasterisers).
//  Revision    : 1.0 - initial release
// ============================================================================
package raster_pkg;

    // Default visible screen geometry.
    localparam int SCREEN_W_DEF = 640;
    localparam int SCREEN_H_DEF = 480;

    // Default coordinate widths used by the packed pixel address.
    localparam int X_W_DEF = 10;
    localparam int Y_W_DEF = 9;

    // Rasteriser control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_STEP = 2'd2,
        ST_FIN  = 2'd3
    } raster_state_t;

    // Pixel address as presented to the pixel writer: x in the high bits.
    typedef struct packed {
        logic [X_W_DEF-1:0] x;
        logic [Y_W_DEF-1:0] y;
    } pix_addr_t;

endpackage
`default_nettype wire

// File: rtl/raster_clip.sv
`default_nettype none
// ============================================================================
//  Module      : raster_clip
//  Description : Combinational screen clipping helpers: point in-bounds test,
//                row in-bounds test and horizontal span clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_clip #(
    parameter int CW       = 12,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic signed [CW-1:0] px,
    input  logic signed [CW-1:0] py,
    input  logic signed [CW-1:0] lo,
    input  logic signed [CW-1:0] hi,
    output logic                 pt_in,
    output logic                 row_in,
    output logic                 span_ok,
    output logic signed [CW-1:0] lo_cl,
    output logic signed [CW-1:0] hi_cl
);

    localparam logic signed [CW-1:0] c_zero = '0;
    localparam logic signed [CW-1:0] c_xmax = CW'(SCREEN_W - 1);
    localparam logic signed [CW-1:0] c_ymax = CW'(SCREEN_H - 1);

    // Bounds tests and span clamp to the visible columns.
    always_comb begin
        row_in  = (py >= c_zero) && (py <= c_ymax);
        pt_in   = row_in && (px >= c_zero) && (px <= c_xmax);
        lo_cl   = (lo < c_zero) ? c_zero : lo;
        hi_cl   = (hi > c_xmax) ? c_xmax : hi;
        span_ok = (lo_cl <= hi_cl);
    end

endmodule
`default_nettype wire

// File: rtl/circle_raster_v2.sv
`default_nettype none
// ============================================================================
//  Module      : circle_raster_v2
//  Description : Midpoint circle rasteriser (outline or filled) with screen
//                clipping, streaming {x, y} pixel addresses over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module circle_raster_v2
    import raster_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int R_W      = 9,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [X_W-1:0]     cx,
    input  logic [Y_W-1:0]     cy,
    input  logic [R_W-1:0]     radius,
    input  logic               fill,
    input  logic               abort,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [X_W+Y_W-1:0] pix_addr,
    output logic               busy,
    output logic               done
);

    localparam int CW = X_W + 2;   // signed coordinate width
    localparam int DW = R_W + 3;   // signed decision-variable width

    localparam logic signed [CW-1:0] c_c_one = {{(CW-1){1'b0}}, 1'b1};
    localparam logic signed [DW-1:0] c_d_one = {{(DW-1){1'b0}}, 1'b1};

    raster_state_t          r_state;
    logic signed [CW-1:0]   r_cx, r_cy, r_x, r_y, r_col;
    logic signed [DW-1:0]   r_d;
    logic                   r_fill;
    logic [2:0]             r_idx;
    logic                   r_col_act;

    logic signed [CW-1:0]   w_ox, w_oy, w_row, w_half;
    logic signed [CW-1:0]   w_px, w_py, w_lo, w_hi, w_lo_cl, w_hi_cl, w_col;
    logic signed [CW-1:0]   w_ex, w_ey;
    logic                   w_pt_in, w_row_in, w_span_ok;
    logic                   w_fill_ok, w_row_done, w_emit_ok, w_last, w_adv;
    logic signed [CW-1:0]   w_y_n, w_x_n;
    logic signed [DW-1:0]   w_y2, w_x2, w_d_n;
    logic                   w_more;

    // Octant offsets for outline points and row/half-width for fill spans.
    always_comb begin
        w_ox   = '0;
        w_oy   = '0;
        w_row  = '0;
        w_half = '0;
        case (r_idx)
            3'd0: begin w_ox =  r_x; w_oy =  r_y; end
            3'd1: begin w_ox =  r_y; w_oy =  r_x; end
            3'd2: begin w_ox = -r_y; w_oy =  r_x; end
            3'd3: begin w_ox = -r_x; w_oy =  r_y; end
            3'd4: begin w_ox = -r_x; w_oy = -r_y; end
            3'd5: begin w_ox = -r_y; w_oy = -r_x; end
            3'd6: begin w_ox =  r_y; w_oy = -r_x; end
            default: begin w_ox = r_x; w_oy = -r_y; end
        endcase
        case (r_idx[1:0])
            2'd0: begin w_row = r_cy + r_y; w_half = r_x; end
            2'd1: begin w_row = r_cy - r_y; w_half = r_x; end
            2'd2: begin w_row = r_cy + r_x; w_half = r_y; end
            default: begin w_row = r_cy - r_x; w_half = r_y; end
        endcase
        w_px = r_cx + w_ox;
        w_py = r_fill ? w_row : (r_cy + w_oy);
        w_lo = r_cx - w_half;
        w_hi = r_cx + w_half;
    end

    raster_clip #(
        .CW       (CW),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .px      (w_px),
        .py      (w_py),
        .lo      (w_lo),
        .hi      (w_hi),
        .pt_in   (w_pt_in),
        .row_in  (w_row_in),
        .span_ok (w_span_ok),
        .lo_cl   (w_lo_cl),
        .hi_cl   (w_hi_cl)
    );

    // Current candidate pixel, its visibility and whether it ends the iteration.
    always_comb begin
        w_adv      = !pix_valid || pix_ready;
        w_col      = r_col_act ? r_col : w_lo_cl;
        w_fill_ok  = w_row_in && w_span_ok;
        w_row_done = !w_fill_ok || (w_col >= w_hi_cl);
        w_emit_ok  = r_fill ? w_fill_ok : w_pt_in;
        w_ex       = r_fill ? w_col : w_px;
        w_ey       = w_py;
        w_last     = r_fill ? ((r_idx == 3'd3) && w_row_done) : (r_idx == 3'd7);
    end

    // Midpoint step: new y first, then x and d using the updated values.
    always_comb begin
        w_y_n  = r_y + c_c_one;
        w_x_n  = r_d[DW-1] ? r_x : (r_x - c_c_one);
        w_y2   = DW'(w_y_n);
        w_x2   = DW'(w_x_n);
        w_d_n  = r_d[DW-1] ? (r_d + (w_y2 <<< 1) + c_d_one)
                           : (r_d + ((w_y2 - w_x2) <<< 1) + c_d_one);
        w_more = (w_y_n <= w_x_n);
    end

    // Control FSM with registered pixel stream and status outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state   <= ST_IDLE;
            r_cx      <= '0;
            r_cy      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_d       <= '0;
            r_col     <= '0;
            r_fill    <= 1'b0;
            r_idx     <= '0;
            r_col_act <= 1'b0;
            pix_valid <= 1'b0;
            pix_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            r_state   <= ST_IDLE;
            r_col_act <= 1'b0;
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cx      <= CW'($signed({1'b0, cx}));
                        r_cy      <= CW'($signed({1'b0, cy}));
                        r_x       <= CW'($signed({1'b0, radius}));
                        r_y       <= '0;
                        r_d       <= c_d_one - DW'($signed({1'b0, radius}));
                        r_fill    <= fill;
                        r_idx     <= '0;
                        r_col_act <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_adv) begin
                        pix_valid <= w_emit_ok;
                        pix_addr  <= {X_W'(w_ex), Y_W'(w_ey)};
                        if (w_last) begin
                            r_idx     <= '0;
                            r_col_act <= 1'b0;
                            r_state   <= ST_STEP;
                        end else if (r_fill && !w_row_done) begin
                            r_col     <= w_col + c_c_one;
                            r_col_act <= 1'b1;
                        end else begin
                            r_idx     <= r_idx + 3'd1;
                            r_col_act <= 1'b0;
                        end
                    end
                end
                ST_STEP: begin
                    if (w_adv) begin
                        pix_valid <= 1'b0;
                        r_y       <= w_y_n;
                        r_x       <= w_x_n;
                        r_d       <= w_d_n;
                        done      <= !w_more;
                        r_state   <= w_more ? ST_EMIT : ST_FIN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_circle_raster_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circle_raster_v2
//  Description : Self-checking bench for circle_raster_v2 with a behavioural
//                pixel-list model and randomized primitives.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_circle_raster_v2;
    import raster_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst, start, fill, abort, pix_ready;
    logic [9:0]  cx;
    logic [8:0]  cy, radius;
    logic        pix_valid, busy, done;
    logic [18:0] pix_addr;

    int          total = 0;
    int          bad = 0;
    logic [18:0] exp_q[$];
    int          exp_n;
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    bit          mon_en = 0;
    bit          ready_rand = 0;
    logic        prev_stall = 1'b0;
    logic [18:0] prev_addr = '0;
    logic [18:0] mon_exp;

    always #5 clk = ~clk;

    circle_raster_v2 dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .cx        (cx),
        .cy        (cy),
        .radius    (radius),
        .fill      (fill),
        .abort     (abort),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_addr  (pix_addr),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [18:0] mk(input int x, input int y);
        pix_addr_t a;
        a.x = x[9:0];
        a.y = y[8:0];
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: list of accepted pixel addresses a primitive must produce.
    task automatic build_model(input int ccx, input int ccy, input int r, input int f);
        int x, y, d, lo, hi;
        int px[8], py[8], rows[4], half[4];
        exp_q.delete();
        x = r; y = 0; d = 1 - r;
        while (x >= y) begin
            if (f == 0) begin
                px = '{ccx+x, ccx+y, ccx-y, ccx-x, ccx-x, ccx-y, ccx+y, ccx+x};
                py = '{ccy+y, ccy+x, ccy+x, ccy+y, ccy-y, ccy-x, ccy-x, ccy-y};
                for (int i = 0; i < 8; i++)
                    if (px[i] >= 0 && px[i] < 640 && py[i] >= 0 && py[i] < 480)
                        exp_q.push_back(mk(px[i], py[i]));
            end else begin
                rows = '{ccy+y, ccy-y, ccy+x, ccy-x};
                half = '{x, x, y, y};
                for (int i = 0; i < 4; i++) begin
                    if (rows[i] >= 0 && rows[i] < 480) begin
                        lo = (ccx - half[i] < 0) ? 0 : ccx - half[i];
                        hi = (ccx + half[i] > 639) ? 639 : ccx + half[i];
                        for (int c = lo; c <= hi; c++)
                            exp_q.push_back(mk(c, rows[i]));
                    end
                end
            end
            y = y + 1;
            if (d < 0) d = d + 2*y + 1;
            else begin x = x - 1; d = d + 2*(y - x) + 1; end
        end
        exp_n = exp_q.size();
    endtask

    // Compare process: every transfer against the model, hold-stability, done.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, pix_valid}, 32'd1);
                check("stall_addr", {13'd0, pix_addr}, {13'd0, prev_addr});
            end
            if (pix_valid && pix_ready && n_rst && !abort) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_pixel: got %h expected none", pix_addr);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("pix_addr", {13'd0, pix_addr}, {13'd0, mon_exp});
                end
            end
            if (done) begin
                done_cnt++;
                check("done_queue_left", exp_q.size(), 32'd0);
            end
            prev_stall = pix_valid && !pix_ready && !abort && n_rst;
            prev_addr  = pix_addr;
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) pix_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic start_prim(input int x, input int y, input int r, input int f);
        build_model(x, y, r, f);
        xfer_cnt = 0;
        done_cnt = 0;
        cx = 10'(x); cy = 9'(y); radius = 9'(r); fill = f[0];
        start = 1'b1;
        tick;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_xfers(input int n);
        int b;
        b = 0;
        while (xfer_cnt < n && b < 5000) begin @(negedge clk); b++; end
        if (xfer_cnt < n) begin
            total++; bad++;
            $display("FAIL wait_xfers: got %0d transfers expected %0d", xfer_cnt, n);
        end
    endtask

    task automatic wait_done;
        int b;
        b = 0;
        while (done_cnt == 0 && b < 20000) begin @(negedge clk); b++; end
        if (done_cnt == 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done");
        end
        check("xfer_count", xfer_cnt, exp_n);
        @(negedge clk);
        @(negedge clk);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("done_pulses", done_cnt, 32'd1);
        tick;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] t3[6];
        logic [18:0] t4[8];
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; fill = 1'b0;
        cx = '0; cy = '0; radius = '0; pix_ready = 1'b1;
        repeat (3) tick;
        @(negedge clk);
        check("rst_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_addr", {13'd0, pix_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        tick;
        n_rst = 1'b1;
        mon_en = 1;
        tick;

        // Pin the model with hand-derived results.
        build_model(320, 240, 3, 0);
        check("model_t2_n", exp_n, 32'd24);
        check("model_t2_first", {13'd0, exp_q[0]}, {13'd0, mk(323, 240)});
        check("model_t2_last", {13'd0, exp_q[23]}, {13'd0, mk(322, 238)});
        build_model(0, 0, 2, 0);
        t3 = '{mk(2,0), mk(0,2), mk(0,2), mk(2,0), mk(2,1), mk(1,2)};
        check("model_t3_n", exp_n, 32'd6);
        for (int i = 0; i < 6 && i < exp_n; i++)
            check("model_t3_pt", {13'd0, exp_q[i]}, {13'd0, t3[i]});
        build_model(10, 10, 1, 1);
        t4 = '{mk(9,10), mk(10,10), mk(11,10), mk(9,10), mk(10,10), mk(11,10), mk(10,11), mk(10,9)};
        check("model_t4_n", exp_n, 32'd8);
        for (int i = 0; i < 8 && i < exp_n; i++)
            check("model_t4_pt", {13'd0, exp_q[i]}, {13'd0, t4[i]});
        exp_q.delete();

        // Test 1: r=0 outline.
        start_prim(100, 100, 0, 0);
        wait_done;
        // Test 2 with a start while busy that must be ignored.
        start_prim(320, 240, 3, 0);
        cx = 10'd7; cy = 9'd7; radius = 9'd50; fill = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        wait_done;
        // Test 3: corner clipping.
        start_prim(0, 0, 2, 0);
        wait_done;
        // Test 4: small fill.
        start_prim(10, 10, 1, 1);
        wait_done;
        // Test 5: stall mid-stream.
        start_prim(320, 240, 3, 0);
        wait_xfers(10);
        tick;
        pix_ready = 1'b0;
        repeat (5) tick;
        pix_ready = 1'b1;
        wait_done;
        // Test 6: abort after the third transfer.
        start_prim(320, 240, 3, 0);
        wait_xfers(3);
        tick;
        abort = 1'b1; pix_ready = 1'b0;
        tick;
        abort = 1'b0; pix_ready = 1'b1;
        @(negedge clk);
        check("abort_valid", {31'd0, pix_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, 32'd0);
        exp_q.delete();
        tick;
        start_prim(5, 5, 0, 0);
        wait_done;
        // start and abort together in IDLE: stay idle.
        start = 1'b1; abort = 1'b1; fill = 1'b0; radius = 9'd4;
        tick;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", {31'd0, busy}, 32'd0);
        check("start_abort_valid", {31'd0, pix_valid}, 32'd0);
        tick;
        // Reset mid-primitive.
        start_prim(320, 240, 10, 1);
        repeat (5) tick;
        n_rst = 1'b0; pix_ready = 1'b0;
        tick;
        n_rst = 1'b1; pix_ready = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_valid", {31'd0, pix_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        tick;
        // Large outline, then randomized primitives with random backpressure.
        start_prim(320, 240, 200, 0);
        wait_done;
        ready_rand = 1;
        for (int n = 0; n < 30; n++) begin
            start_prim($urandom_range(0, 700), $urandom_range(0, 511),
                       $urandom_range(0, 20), $urandom_range(0, 1));
            wait_done;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
